// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic ALU_OP_DIV = 1'b0;
    localparam logic ALU_OP_MUL = 1'b1;

    // Wide enough for any supported operand width; users slice the low bits.
    localparam int              MAX_L            = 64;
    localparam logic [MAX_L-1:0] DIV_BY_ZERO_QUOT = '1;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int l = 16
) (
    input  logic         op_i,
    input  logic [l-1:0] acc_i,
    input  logic [l-1:0] lo_i,
    input  logic [l-1:0] operand_i,
    output logic [l-1:0] acc_o,
    output logic [l-1:0] lo_o
);

    logic [l:0]   sum;
    logic [l:0]   rem_s;
    logic         ge;
    logic [l-1:0] diff;

    always_comb begin
        sum   = {1'b0, acc_i} + (lo_i[0] ? {1'b0, operand_i} : '0);
        // The shifted remainder needs one extra bit before the trial subtract.
        rem_s = {acc_i, lo_i[l-1]};
        ge    = rem_s >= {1'b0, operand_i};
        // When ge holds the true difference is below the divisor, so l bits suffice.
        diff  = rem_s[l-1:0] - operand_i;

        if (op_i == ALU_OP_MUL) begin
            acc_o = sum[l:1];
            lo_o  = {sum[0], lo_i[l-1:1]};
        end else if (ge) begin
            acc_o = diff;
            lo_o  = {lo_i[l-2:0], 1'b1};
        end else begin
            acc_o = rem_s[l-1:0];
            lo_o  = {lo_i[l-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MUL/DIV sequencer with Busy/Done handshake.
// Optional MULDIV_EARLY_EXIT_EN: MUL stops once the remaining multiplier bits are zero.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int l     = 16,
    parameter int cnt_w = 5
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Start,
    input  logic         ALUOpcode,
    input  logic [l-1:0] OperandA,
    input  logic [l-1:0] OperandB,
    output logic         Busy,
    output logic         Done,
    output logic [l-1:0] Result,
    output logic [l-1:0] ResultHigh,
    output logic         Zero,
    output logic         Overflow,
    output logic         DivByZero,
    output state_t       DbgState
);

    // Handshake: Start is taken on any edge where Busy=0 (IDLE or DONE);
    // Done is a one-cycle pulse and results stay valid until the next Done.
    state_t         state_q;
    logic [cnt_w-1:0] cnt_q;
    logic           op_q;
    logic [l-1:0]   acc_q, lo_q, opnd_q;
    logic [l-1:0]   acc_d, lo_d;
    logic           busy_q, done_q;
    logic [l-1:0]   result_q, result_hi_q;
    logic           zero_q, ovf_q, dbz_q;
    logic           last_iter;
    logic [2*l-1:0] final_d;

    muldiv_step #(.l(l)) u_step (
        .op_i      (op_q),
        .acc_i     (acc_q),
        .lo_i      (lo_q),
        .operand_i (opnd_q),
        .acc_o     (acc_d),
        .lo_o      (lo_d)
    );

`ifdef MULDIV_EARLY_EXIT_EN
    logic [l-1:0] mplr_q, mplr_d;
    assign mplr_d    = mplr_q >> 1;
    assign last_iter = (cnt_q == cnt_w'(l-1)) || (op_q == ALU_OP_MUL && mplr_d == '0);
    // Skipped iterations would only shift right, so apply them in one step.
    assign final_d   = {acc_d, lo_d} >> (cnt_w'(l-1) - cnt_q);
`else
    assign last_iter = (cnt_q == cnt_w'(l-1));
    assign final_d   = {acc_d, lo_d};
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= ALU_OP_DIV;
            acc_q       <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
            mplr_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + cnt_w'(1);
`ifdef MULDIV_EARLY_EXIT_EN
                    mplr_q <= mplr_d;
`endif
                    if (last_iter) begin
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        result_q    <= final_d[l-1:0];
                        result_hi_q <= final_d[2*l-1:l];
                        zero_q      <= (final_d[l-1:0] == '0);
                        ovf_q       <= (op_q == ALU_OP_MUL) && (final_d[2*l-1:l] != '0);
                        dbz_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (Start) begin
                        op_q   <= ALUOpcode;
                        cnt_q  <= '0;
                        acc_q  <= '0;
                        opnd_q <= (ALUOpcode == ALU_OP_MUL) ? OperandA : OperandB;
                        lo_q   <= (ALUOpcode == ALU_OP_MUL) ? OperandB : OperandA;
`ifdef MULDIV_EARLY_EXIT_EN
                        mplr_q <= OperandB;
`endif
                        if (ALUOpcode == ALU_OP_DIV && OperandB == '0) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            result_q    <= DIV_BY_ZERO_QUOT[l-1:0];
                            result_hi_q <= OperandA;
                            zero_q      <= 1'b0;
                            ovf_q       <= 1'b0;
                            dbz_q       <= 1'b1;
                        end
`ifdef MULDIV_EARLY_EXIT_EN
                        else if (ALUOpcode == ALU_OP_MUL && OperandB == '0) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            result_q    <= '0;
                            result_hi_q <= '0;
                            zero_q      <= 1'b1;
                            ovf_q       <= 1'b0;
                            dbz_q       <= 1'b0;
                        end
`endif
                        else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Result     = result_q;
    assign ResultHigh = result_hi_q;
    assign Zero       = zero_q;
    assign Overflow   = ovf_q;
    assign DivByZero  = dbz_q;
    assign DbgState   = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed table, handshake corner sequences, random vs arithmetic model.
`timescale 1ns/1ps
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W  = 16;
  localparam int EW = 8 + 3 + 2 * W;  // {lat, dbz, ovf, zero, hi, res}
`ifdef MULDIV_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         alu_op = 1'b0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         busy, done, zero, ovf, dbz;
  logic [W-1:0] res, res_hi;
  state_t       dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         o;
    logic         d;
    int           lat;
  } vec_t;
  vec_t vecs[10];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  muldiv_sequencer #(.l(W), .cnt_w(5)) dut (
    .Clock      (clk),
    .Reset      (rst),
    .Start      (start),
    .ALUOpcode  (alu_op),
    .OperandA   (opa),
    .OperandB   (opb),
    .Busy       (busy),
    .Done       (done),
    .Result     (res),
    .ResultHigh (res_hi),
    .Zero       (zero),
    .Overflow   (ovf),
    .DivByZero  (dbz),
    .DbgState   (dbg_state)
  );

  // ---------------- model / scoreboard helpers ----------------
  function automatic logic [EW-1:0] pack(input int lat, input logic d, input logic o,
                                         input logic z, input logic [W-1:0] hi,
                                         input logic [W-1:0] r);
    return {8'(lat), d, o, z, hi, r};
  endfunction

  function automatic logic [EW-1:0] model(input logic op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [2*W-1:0] p;
    int lat;
    if (op == ALU_OP_MUL) begin
      p   = (2*W)'(a) * (2*W)'(b);
      lat = W + 1;
      if (EE) begin
        lat = 1;
        for (int k = 0; k < W; k++) if (b[k]) lat = k + 2;
      end
      return pack(lat, 1'b0, p[2*W-1:W] != '0, p[W-1:0] == '0, p[2*W-1:W], p[W-1:0]);
    end
    if (b == '0) return pack(1, 1'b1, 1'b0, 1'b0, a, {W{1'b1}});
    return pack(W + 1, 1'b0, 1'b0, (a / b) == '0, a % b, a / b);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [EW-1:0] e);
    start  = 1'b1;
    alu_op = op;
    opa    = a;
    opb    = b;
    exp_q.push_back(e);
  endtask

  // Waits for Done (bounded), returns positioned at the Done negedge.
  task automatic wait_check(input string tag, input int pulse_at);
    logic [EW-1:0] e;
    int lat;
    int bad_busy;
    @(negedge clk);
    start  = 1'b0;
    opa    = W'($urandom);
    opb    = W'($urandom);
    alu_op = 1'($urandom_range(1, 0));
    lat = 1;
    bad_busy = 0;
    while (!done && lat < 40) begin
      if (!busy) bad_busy++;
      if (lat == pulse_at) begin
        start  = 1'b1;
        alu_op = ALU_OP_MUL;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".lat"}, 32'(lat), 32'(e[EW-1:EW-8]));
    check({tag, ".busy_run"}, 32'(bad_busy), 32'd0);
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    check({tag, ".state"}, 32'(dbg_state), 32'(ST_DONE));
    check({tag, ".result"}, 32'(res), 32'(e[W-1:0]));
    check({tag, ".result_high"}, 32'(res_hi), 32'(e[2*W-1:W]));
    check({tag, ".zero"}, 32'(zero), 32'(e[2*W]));
    check({tag, ".overflow"}, 32'(ovf), 32'(e[2*W+1]));
    check({tag, ".div_by_zero"}, 32'(dbz), 32'(e[2*W+2]));
  endtask

  // ---------------- test ----------------
  initial begin
    int done_seen;

    vecs[0] = '{1'b1, 16'd300,   16'd300, 16'h5F90, 16'h0001, 1'b0, 1'b1, 1'b0, EE ? 10 : 17};
    vecs[1] = '{1'b0, 16'd1000,  16'd7,   16'd142,  16'd6,    1'b0, 1'b0, 1'b0, 17};
    vecs[2] = '{1'b0, 16'h1234,  16'd0,   16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b1, 1};
    vecs[3] = '{1'b1, 16'd100,   16'd3,   16'd300,  16'd0,    1'b0, 1'b0, 1'b0, EE ? 3 : 17};
    vecs[4] = '{1'b1, 16'hFFFF,  16'hFFFF,16'h0001, 16'hFFFE, 1'b0, 1'b1, 1'b0, 17};
    vecs[5] = '{1'b0, 16'hFFFF,  16'd1,   16'hFFFF, 16'd0,    1'b0, 1'b0, 1'b0, 17};
    vecs[6] = '{1'b0, 16'd5,     16'd9,   16'd0,    16'd5,    1'b1, 1'b0, 1'b0, 17};
    vecs[7] = '{1'b1, 16'd0,     16'd5,   16'd0,    16'd0,    1'b1, 1'b0, 1'b0, EE ? 4 : 17};
    vecs[8] = '{1'b1, 16'd1234,  16'd0,   16'd0,    16'd0,    1'b1, 1'b0, 1'b0, EE ? 1 : 17};
    vecs[9] = '{1'b0, 16'd0,     16'd0,   16'hFFFF, 16'd0,    1'b0, 1'b0, 1'b1, 1};

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.result", 32'(res), 32'd0);
    check("reset.result_high", 32'(res_hi), 32'd0);
    check("reset.flags", 32'({zero, ovf, dbz}), 32'd0);
    check("reset.state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].a, vecs[i].b,
            pack(vecs[i].lat, vecs[i].d, vecs[i].o, vecs[i].z, vecs[i].hi, vecs[i].res));
      wait_check($sformatf("vec%0d", i), 0);
    end
    @(negedge clk);
    check("hold.done_pulse", 32'(done), 32'd0);
    check("hold.result", 32'(res), 32'hFFFF);
    check("hold.div_by_zero", 32'(dbz), 32'd1);

    // back-to-back issue in the DONE cycle, with an ignored Start during RUN
    @(negedge clk);
    issue(ALU_OP_MUL, 16'd0, 16'd5, pack(EE ? 4 : 17, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0));
    wait_check("b2b_mul", 0);
    issue(ALU_OP_DIV, 16'd9, 16'd3, pack(17, 1'b0, 1'b0, 1'b0, 16'd0, 16'd3));
    wait_check("b2b_div", 4);
    @(negedge clk);
    check("b2b.done_pulse", 32'(done), 32'd0);
    check("b2b.hold", 32'(res), 32'd3);

    // reset mid-operation
    @(negedge clk);
    start = 1'b1; alu_op = ALU_OP_MUL; opa = 16'd300; opb = 16'd300;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.result", 32'(res), 32'd0);
    check("abort.result_high", 32'(res_hi), 32'd0);
    check("abort.state", 32'(dbg_state), 32'(ST_IDLE));
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort.no_done", 32'(done_seen), 32'd0);
    @(negedge clk);
    issue(ALU_OP_DIV, 16'd1000, 16'd7, pack(17, 1'b0, 1'b0, 1'b0, 16'd6, 16'd142));
    wait_check("post_abort", 0);

    // randomized against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op = 1'($urandom_range(1, 0));
      a  = W'($urandom);
      case ($urandom_range(3, 0))
        0:       b = '0;
        1:       b = W'($urandom_range(15, 1));
        default: b = W'($urandom);
      endcase
      if ($urandom_range(1, 0) == 0) @(negedge clk);
      issue(op, a, b, model(op, a, b));
      wait_check($sformatf("rnd%0d", i), 0);
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle iterative unsigned multiply/divide engine plus the FSM that sequences it. Replaces the single-cycle MUL/DIV path selected by ALUOpcode.
- Control unit decodes MUL/DIV/MULi/DIVi and muxes the operands externally. This block accepts one operation per Start, iterates one bit per cycle, and reports Result, Remainder/High and flags with a Busy/Done handshake.
- Pipeline stall logic holds issue while Busy=1.

Parameters:
- l, 16, operand/result width in bits
- cnt_w, 5, iteration counter width; must satisfy 2^cnt_w > l

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Start  input  1  request a new operation; sampled only when Busy=0
- ALUOpcode  input  1  1 = MUL, 0 = DIV (same encoding as control unit)
- OperandA  input  l  multiplicand / dividend
- OperandB  input  l  multiplier / divisor (register or immediate, muxed upstream)
- Busy  output  1  operation in progress; Start ignored
- Done  output  1  one-cycle pulse; results valid this cycle
- Result  output  l  MUL: product[l-1:0]; DIV: quotient
- ResultHigh  output  l  MUL: product[2l-1:l]; DIV: remainder
- Zero  output  1  Result == 0
- Overflow  output  1  MUL: ResultHigh != 0; DIV: 0
- DivByZero  output  1  DIV with OperandB == 0

Behaviour:
- Reset: state IDLE, counter 0, Busy=0, Done=0, Result=0, ResultHigh=0, all flags 0. Reset mid-operation aborts and discards partial results.
- States and transitions:
  - IDLE: Start=1 latches operands and opcode. Go to RUN, except DIV with B=0, which goes to DONE.
  - RUN: one iteration per cycle, counter 0..l-1. Go to DONE after iteration l-1.
  - DONE: Done=1 for exactly one cycle, then IDLE.
- Busy=1 in RUN only. DONE counts as not busy: a Start in the DONE cycle is accepted and the next state is RUN (or DONE for div-by-zero). This gives back-to-back issue.
- Latency: Start sampled at edge T → RUN cycles T+1..T+l → Done high in cycle T+l+1 (l+1 cycles). Div-by-zero: Done in cycle T+1.
- MUL iteration (shift-add):
  - If multiplier LSB=1, acc_hi += multiplicand (l+1-bit add with carry).
  - Then shift {carry, acc_hi, multiplier} right by 1.
- DIV iteration (restoring):
  - Shift {rem, quot} left by 1.
  - trial = rem - divisor (l+1 bits). If trial is non-negative, rem=trial and quot[0]=1.
- Div-by-zero: Result = all ones, ResultHigh = OperandA, DivByZero=1, Zero=0.
- Output registers:
  - Result, ResultHigh and flags update only on the edge entering DONE.
  - They hold their values through IDLE until the next DONE.
  - Flags are cleared only by Reset.
- Arithmetic is unsigned. Operands are latched at Start; input changes during RUN have no effect.
- Start with Busy=1 is dropped silently and does not queue.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined, MUL only:
  - If OperandB==0 at Start, go directly to DONE (Done in T+1).
  - In RUN, when the multiplier shift register becomes 0 after an iteration, the next state is DONE.
  - Iterations = index of highest set bit of B, plus 1.
  - Result values are identical to the full run. DIV is unaffected.
- Undefined: fixed l iterations for every non-div-by-zero operation.

Decomposition:
- Package muldiv_pkg:
  - State encoding: ST_IDLE, ST_RUN, ST_DONE.
  - ALU opcode constants: ALU_OP_DIV=1'b0, ALU_OP_MUL=1'b1.
  - Div-by-zero quotient constant (all ones).
- Sub-module muldiv_step: purely combinational single-iteration datapath.
  - Inputs: opcode, acc/rem, multiplier/quot, operand.
  - Outputs: next values.
- Sequencer keeps the FSM, counter, operand registers and output registers.

Test Plan:
- MUL 300 × 300 → Done at T+17, Result=0x5F90, ResultHigh=0x0001, Overflow=1, Zero=0, Busy high T+1..T+16.
- DIV 1000 / 7 → Done at T+17, Result=142, ResultHigh=6, Overflow=0, DivByZero=0.
- DIV 0x1234 / 0 → Done at T+1, Result=0xFFFF, ResultHigh=0x1234, DivByZero=1.
- Back-to-back:
  - MUL 0 × 5 → Zero=1.
  - Start in its DONE cycle with DIV 9 / 3 → accepted, second Done 17 cycles later with Result=3.
  - Start pulsed at T+5 during RUN → ignored.
- Reset asserted at T+8 mid-MUL → next cycle Busy=0, Done=0, Result=0. No Done pulse follows. A new Start then completes normally.
- With MULDIV_EARLY_EXIT_EN: MUL 100 × 3 → Done at T+3, Result=300. Without the macro → Done at T+17, Result=300.
